// File: rtl/apb_master_bridge_pkg.sv
// apb_pkg: shared types for the APB3 requester bridge.
// FSM state encoding, response bundle and address alignment helper.
package apb_pkg;

    // APB3 data buses are at most 32 bits wide.
    localparam int APB_DATA_W = 32;

    // Low address bits that must be zero for a word-aligned access.
    localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    function automatic logic addr_misaligned(input logic [1:0] lo);
        return (lo & APB_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command, response and APB bus signals of the bridge.
// master = bridge side, slave = command source plus APB peripheral side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_wdata,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output rsp_timeout,
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_wdata,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  rsp_timeout,
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// apb_wait_timer: counts ACCESS wait states and flags the last allowed one.
// TIMEOUT = 0 disables the abort; the count saturates instead of wrapping.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt;

    // Wait-state counter: cleared before ACCESS, bumped per stalled cycle.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB3 requester for the timer/interrupt subsystem.
// Turns single-beat local commands into SETUP/ACCESS transfers, one response each.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter bit CHECK_ALGN = 1'b1
) (
    input  logic                pclk,
    input  logic                preset_n,
    apb_master_bridge_if.master bus
);

    apb_state_t        state_q;
    apb_state_t        state_d;

    logic              ready_en_q;
    logic              cmd_ready_c;
    logic              psel_c;
    logic              penable_c;
    logic              accept;
    logic              misalgn;

    logic              tmr_clear;
    logic              tmr_inc;
    logic              tmr_expired;

    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;

    logic              rsp_load;
    apb_rsp_t          rsp_d;
    logic              rsp_valid_q;
    apb_rsp_t          rsp_q;

    assign misalgn = CHECK_ALGN && addr_misaligned(bus.cmd_addr[1:0]);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clear    (tmr_clear),
        .inc      (tmr_inc),
        .expired  (tmr_expired)
    );

    // Next state, bus strobes and the response to register this edge.
    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        psel_c      = 1'b0;
        penable_c   = 1'b0;
        accept      = 1'b0;
        tmr_clear   = 1'b0;
        tmr_inc     = 1'b0;
        rsp_load    = 1'b0;
        rsp_d       = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_c = ready_en_q;
                if (bus.cmd_valid && ready_en_q) begin
                    accept = 1'b1;
                    if (misalgn) begin
                        rsp_load  = 1'b1;
                        rsp_d.err = 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                psel_c    = 1'b1;
                tmr_clear = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                if (bus.pready) begin
                    state_d   = IDLE;
                    rsp_load  = 1'b1;
                    rsp_d.err = bus.pslverr;
                    if (!pwrite_q && !bus.pslverr) begin
                        rsp_d.rdata = APB_DATA_W'(bus.prdata);
                    end
                end else if (tmr_expired) begin
                    state_d       = IDLE;
                    rsp_load      = 1'b1;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any transfer in flight.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holds cmd_ready low until the first edge after reset is released.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Command latch: drives the APB address phase and holds it afterwards.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (accept) begin
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
        end
    end

    // Response register: one-cycle pulse, fields zero when not valid.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_load;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.psel        = psel_c;
    assign bus.penable     = penable_c;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: random command/slave timeline against a cycle model.
// The model lays out each transfer's expected bus and response cycles up front.
module tb_apb_master_bridge;

    localparam int TMO  = 8;
    localparam int MAXC = 4096;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pready;
        logic [31:0] prdata;
        logic        slverr;
    } drv_t;

    typedef struct packed {
        logic        ready;
        logic        psel;
        logic        pen;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    logic pclk = 1'b0;
    logic preset_n = 1'b0;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT    (TMO),
        .CHECK_ALGN (1'b1)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    always #5 pclk = ~pclk;

    drv_t drv [MAXC];
    exp_t ex  [MAXC];
    exp_t e;

    int   t;
    int   nc;
    int   total = 0;
    int   bad = 0;
    int   abort_c = -10;
    bit   built = 1'b0;

    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        pend_v;
    logic        pend_err;
    logic        pend_tmo;
    logic [31:0] pend_rdata;

    function automatic void put(input logic rdy, input logic ps, input logic pe);
        ex[t]        = '0;
        ex[t].ready  = rdy;
        ex[t].psel   = ps;
        ex[t].pen    = pe;
        ex[t].pwrite = cur_write;
        ex[t].paddr  = cur_addr;
        ex[t].pwdata = cur_wdata;
    endfunction

    function automatic void idle_cyc();
        put(1'b1, 1'b0, 1'b0);
        if (pend_v) begin
            ex[t].rv    = 1'b1;
            ex[t].rdata = pend_rdata;
            ex[t].err   = pend_err;
            ex[t].tmo   = pend_tmo;
        end
        pend_v = 1'b0;
        t++;
    endfunction

    function automatic void busy_cyc(input logic pe);
        put(1'b0, 1'b1, pe);
        if ($urandom_range(0, 1) == 1) drv[t].valid = 1'b1;
        t++;
    endfunction

    function automatic void reset_tail(input int n);
        for (int i = 0; i < n; i++) begin
            ex[t] = '0;
            drv[t].rst = (i == n - 1);
            if ($urandom_range(0, 1) == 1) drv[t].valid = 1'b1;
            t++;
        end
        cur_write = 1'b0;
        cur_addr  = '0;
        cur_wdata = '0;
        pend_v    = 1'b0;
    endfunction

    function automatic void present(input logic w, input logic [31:0] a,
                                    input logic [31:0] d);
        drv[t].valid = 1'b1;
        drv[t].write = w;
        drv[t].addr  = a;
        drv[t].wdata = d;
        idle_cyc();
        cur_write = w;
        cur_addr  = a;
        cur_wdata = d;
    endfunction

    function automatic void cmd(input logic w, input logic [31:0] a,
                                input logic [31:0] d, input int waits,
                                input logic [31:0] pd, input logic se);
        int len;
        present(w, a, d);
        if (a[1:0] != 2'b00) begin
            pend_v     = 1'b1;
            pend_err   = 1'b1;
            pend_tmo   = 1'b0;
            pend_rdata = '0;
            return;
        end
        busy_cyc(1'b0);
        len = (waits >= TMO) ? TMO : waits + 1;
        for (int j = 0; j < len; j++) begin
            drv[t].pready = (j >= waits);
            if (j >= waits) begin
                drv[t].prdata = pd;
                drv[t].slverr = se;
            end
            busy_cyc(1'b1);
        end
        pend_v = 1'b1;
        if (waits >= TMO) begin
            pend_err   = 1'b1;
            pend_tmo   = 1'b1;
            pend_rdata = '0;
        end else begin
            pend_err   = se;
            pend_tmo   = 1'b0;
            pend_rdata = (!w && !se) ? pd : 32'h0;
        end
    endfunction

    function automatic void cmd_abort(input logic [31:0] a, input int k);
        present(1'b0, a, 32'h1234_5678);
        busy_cyc(1'b0);
        for (int j = 0; j < k; j++) begin
            drv[t].pready = 1'b0;
            busy_cyc(1'b1);
        end
        abort_c = t - 1;
        drv[abort_c].rst = 1'b0;
        reset_tail(3);
    endfunction

    function automatic void build();
        logic [31:0] a;
        int          sel;
        int          waits;
        for (int c = 0; c < MAXC; c++) begin
            drv[c].rst    = 1'b1;
            drv[c].valid  = 1'b0;
            drv[c].write  = 1'($urandom_range(0, 1));
            drv[c].addr   = $urandom;
            drv[c].wdata  = $urandom;
            drv[c].pready = 1'($urandom_range(0, 1));
            drv[c].prdata = $urandom;
            drv[c].slverr = 1'($urandom_range(0, 1));
            ex[c] = '0;
        end
        t = 0;
        reset_tail(4);
        cmd(1'b1, 32'h0, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        cmd(1'b0, 32'h8, 32'h0, 2, 32'h3, 1'b0);
        cmd(1'b0, 32'hC, 32'h0, 0, 32'h5A5A_5A5A, 1'b1);
        cmd(1'b0, 32'h10, 32'h0, 100, 32'h0, 1'b0);
        cmd(1'b1, 32'h0, 32'h1111_1111, 0, 32'h0, 1'b0);
        cmd(1'b1, 32'h4, 32'h2222_2222, 0, 32'h0, 1'b0);
        cmd(1'b1, 32'h8, 32'h3333_3333, 0, 32'h0, 1'b0);
        cmd(1'b1, 32'h6, 32'h4444_4444, 0, 32'h0, 1'b0);
        cmd(1'b0, 32'h20, 32'h0, 7, 32'h600D_F00D, 1'b0);
        for (int i = 0; i < 160 && t < MAXC - 200; i++) begin
            for (int g = $urandom_range(0, 3); g > 1; g--) idle_cyc();
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
            end else begin
                a[1:0] = 2'b00;
            end
            sel = $urandom_range(0, 9);
            if (sel <= 5)      waits = $urandom_range(0, 3);
            else if (sel == 6) waits = TMO - 1;
            else if (sel == 7) waits = TMO;
            else if (sel == 8) waits = $urandom_range(TMO + 1, 20);
            else               waits = 0;
            cmd(1'($urandom_range(0, 1)), a, $urandom, waits, $urandom,
                $urandom_range(0, 4) == 0);
        end
        idle_cyc();
        idle_cyc();
        cmd_abort(32'h40, 2);
        cmd(1'b0, 32'h44, 32'h0, 1, 32'hCAFE_0001, 1'b0);
        cmd(1'b1, 32'h48, 32'hCAFE_0002, 0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) idle_cyc();
        nc = t;
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, c, got, want);
        end
    endtask

    task automatic chkb(input string nm, input int c, input logic got,
                        input logic want);
        chk(nm, c, {31'b0, got}, {31'b0, want});
    endtask

    // Stimulus: replays the planned input timeline, one entry per cycle.
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        build();
        built = 1'b1;
        for (int c = 0; c < nc; c++) begin
            @(posedge pclk);
            #1;
            preset_n      = drv[c].rst;
            bus.cmd_valid = drv[c].valid;
            bus.cmd_write = drv[c].write;
            bus.cmd_addr  = drv[c].addr;
            bus.cmd_wdata = drv[c].wdata;
            bus.pready    = drv[c].pready;
            bus.prdata    = drv[c].prdata;
            bus.pslverr   = drv[c].slverr;
        end
    end

    // Compare: every cycle against the model, plus fixed literal points.
    initial begin
        wait (built);
        for (int c = 0; c < nc; c++) begin
            @(negedge pclk);
            e = ex[c];
            chkb("cmd_ready", c, bus.cmd_ready, e.ready);
            chkb("psel", c, bus.psel, e.psel);
            chkb("penable", c, bus.penable, e.pen);
            chkb("pwrite", c, bus.pwrite, e.pwrite);
            chk("paddr", c, bus.paddr, e.paddr);
            chk("pwdata", c, bus.pwdata, e.pwdata);
            chkb("rsp_valid", c, bus.rsp_valid, e.rv);
            chk("rsp_rdata", c, bus.rsp_rdata, e.rdata);
            chkb("rsp_err", c, bus.rsp_err, e.err);
            chkb("rsp_timeout", c, bus.rsp_timeout, e.tmo);
            if (c == 3) chkb("lit_ready_in_reset", c, bus.cmd_ready, 1'b0);
            if (c == 4) chkb("lit_ready_after_rst", c, bus.cmd_ready, 1'b1);
            if (c == 5) chk("lit_t1_setup", c, {30'b0, bus.psel, bus.penable}, 32'h2);
            if (c == 6) chk("lit_t1_pwdata", c, bus.pwdata, 32'hDEAD_BEEF);
            if (c == 7) chk("lit_t1_rsp", c, {30'b0, bus.rsp_valid, bus.rsp_err}, 32'h2);
            if (c == 12) chk("lit_t2_rdata", c, bus.rsp_rdata, 32'h3);
            if (c == 15) chk("lit_t3_slverr", c,
                             {bus.rsp_rdata[29:0], bus.rsp_err, bus.rsp_timeout}, 32'h2);
            if (c == 24) chkb("lit_t4_last_access", c, bus.penable, 1'b1);
            if (c == 25) chk("lit_t4_timeout", c,
                             {28'b0, bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'h7);
            if (c == 28) chk("lit_t5_gap", c, {30'b0, bus.psel, bus.rsp_valid}, 32'h1);
            if (c == 35) chk("lit_t6_misalign", c,
                             {29'b0, bus.psel, bus.rsp_valid, bus.rsp_err}, 32'h3);
            if (c == 45) chk("lit_wait7_rdata", c, bus.rsp_rdata, 32'h600D_F00D);
            if (c == abort_c + 1) chkb("lit_abort_psel", c, bus.psel, 1'b0);
            if (c > abort_c && c <= abort_c + 4)
                chkb("lit_abort_no_rsp", c, bus.rsp_valid, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
